pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/squash sequencer for the 5-stage LC-3b pipeline. Each cycle it drives the load enables and squash strobes of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC register from four inputs: I-cache and D-cache handshakes, the decode-stage load-use hazard, and the MEM-stage branch mispredict. It owns the redirect target, so a mispredict that lands while a fetch is in flight is held until that fetch drains.

## Interface
- No parameters.
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- imem_req  in  1  IF stage has a fetch outstanding.
- imem_resp  in  1  fetch completes this cycle.
- dmem_req  in  1  MEM stage instruction accesses memory.
- dmem_resp  in  1  data access completes this cycle.
- load_use  in  1  ID instruction sources the destination of a load in EX.
- mispredict  in  1  MEM-stage branch resolved against its prediction.
- redirect_target  in  16  correct PC, valid with mispredict.
- perf_clr  in  1  synchronous clear of perf counters (macro only).
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  latch enables.
- squash_if_id, squash_id_ex, squash_ex_mem  out  1 each  load a NOP bubble into that latch.
- pc_sel_redirect  out  1  PC mux selects redirect_pc.
- redirect_pc  out  16  registered redirect target.
- stall_cycles, squash_count  out  16 each  perf counters (macro only).

## Operation
- States: BOOT, RUN, DRAIN.
- BOOT is entered on reset and lasts one cycle. It asserts squash_* and load_* on all latches and holds load_pc at 0. It then moves to RUN.
- RUN evaluates conditions in priority order. The first match wins:
  1. dstall = dmem_req & ~dmem_resp. All loads are 0 and all squashes are 0. mispredict is ignored.
  2. mispredict. Load all latches and squash IF/ID, ID/EX and EX/MEM.
     - If imem_req & ~imem_resp: capture redirect_target, hold the PC, and go to DRAIN.
     - Otherwise: pc_sel_redirect=1, drive redirect_pc combinationally from redirect_target, and load_pc=1.
  3. load_use. load_pc=0 and load_if_id=0. ID/EX loads a bubble. EX/MEM and MEM/WB advance.
  4. istall = imem_req & ~imem_resp. load_pc=0. IF/ID loads a bubble. Downstream latches advance.
  5. None of the above: all latches and the PC load, with no squash.
- DRAIN waits for the wrong-path fetch to finish:
  - Back-end stages keep advancing, subject to dstall, which still freezes everything.
  - IF/ID is held squashed.
  - When imem_resp arrives: discard the fetch (squash_if_id=1), pc_sel_redirect=1, load_pc=1 with the registered redirect_pc, then return to RUN.
  - A further mispredict in DRAIN is impossible, because the older stages are bubbles. The controller ignores it.
- redirect_pc is 16 bits and is never modified. Bit 0 is passed through unchanged.

## Timing
- Outputs are combinational from state and inputs. There is no added latency: enables apply at the next rising edge.
- A mispredict with an idle fetch redirects the PC in the same cycle.
- With a fetch in flight, the redirect occurs in the imem_resp cycle. If imem_resp and mispredict coincide, the fetch counts as done and the redirect happens immediately, with no DRAIN.
- Reset values: state=BOOT, redirect_pc=0x0000, counters=0. During reset_n=0 all load_* and squash_* are 0.
- Reset asserted mid-DRAIN abandons the pending redirect.
- dstall and istall together: dstall wins and the whole pipe freezes.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles increments on every RUN or DRAIN cycle where any of load_pc, load_if_id or load_id_ex is 0.
  - squash_count increments by 1 per mispredict accepted in RUN.
  - Both counters saturate at 0xFFFF.
  - perf_clr zeroes both and takes priority over increment.
- Undefined: the counter flops are absent, the outputs are tied to 0, and perf_clr is unused.

## Test plan
- Release reset, no requests → one BOOT cycle with all squashes and load_pc=0, then all loads=1 and squashes=0 every cycle.
- dmem_req=1 with dmem_resp delayed 3 cycles, plus mispredict in cycle 2 → all loads 0 for 3 cycles, then the redirect is taken in the dmem_resp cycle.
- load_use pulse for 1 cycle → load_pc=load_if_id=0, squash_id_ex=1, load_ex_mem=load_mem_wb=1; normal on the next cycle.
- mispredict with target 0x3A00 while imem outstanding 2 more cycles → DRAIN, then pc_sel_redirect=1, redirect_pc=0x3A00, load_pc=1 and squash_if_id=1 on imem_resp; RUN next.
- mispredict and imem_resp in the same cycle with target 0x1234 → immediate redirect to 0x1234, state stays RUN.
- With PIPE_CTRL_PERF_EN: 70000 forced istall cycles → stall_cycles=0xFFFF; perf_clr → 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake and control bundle between the pipeline datapath and pipeline_ctrl.
// master: the controller (drives latch enables, squashes, PC select, perf counters).
// slave:  the datapath side (drives cache handshakes, hazards, mispredict).
interface pipeline_ctrl_if;
  logic        imem_req;
  logic        imem_resp;
  logic        dmem_req;
  logic        dmem_resp;
  logic        load_use;
  logic        mispredict;
  logic [15:0] redirect_target;
  logic        perf_clr;

  logic        load_pc;
  logic        load_if_id;
  logic        load_id_ex;
  logic        load_ex_mem;
  logic        load_mem_wb;
  logic        squash_if_id;
  logic        squash_id_ex;
  logic        squash_ex_mem;
  logic        pc_sel_redirect;
  logic [15:0] redirect_pc;
  logic [15:0] stall_cycles;
  logic [15:0] squash_count;

  modport master (
    input  imem_req, imem_resp, dmem_req, dmem_resp, load_use, mispredict,
    input  redirect_target, perf_clr,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    output squash_if_id, squash_id_ex, squash_ex_mem,
    output pc_sel_redirect, redirect_pc, stall_cycles, squash_count
  );

  modport slave (
    output imem_req, imem_resp, dmem_req, dmem_resp, load_use, mispredict,
    output redirect_target, perf_clr,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    input  squash_if_id, squash_id_ex, squash_ex_mem,
    input  pc_sel_redirect, redirect_pc, stall_cycles, squash_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/squash sequencer for the 5-stage LC-3b pipeline.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl (
  input  logic            clk,
  input  logic            reset_n,
  pipeline_ctrl_if.master io_pipe
);

  typedef enum logic [1:0] {StBoot, StRun, StDrain} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [15:0] r_redirect_pc;
  logic        w_capture;
  logic        w_dstall;
  logic        w_istall;

  logic w_load_pc, w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb;
  logic w_squash_if_id, w_squash_id_ex, w_squash_ex_mem, w_pc_sel;
  logic [15:0] w_redirect_pc;

  assign w_dstall = io_pipe.dmem_req & ~io_pipe.dmem_resp;
  assign w_istall = io_pipe.imem_req & ~io_pipe.imem_resp;

  // Next state and per-cycle latch control, prioritised dstall > mispredict > load_use > istall.
  always_comb begin
    w_state_d       = r_state;
    w_capture       = 1'b0;
    w_load_pc       = 1'b0;
    w_load_if_id    = 1'b0;
    w_load_id_ex    = 1'b0;
    w_load_ex_mem   = 1'b0;
    w_load_mem_wb   = 1'b0;
    w_squash_if_id  = 1'b0;
    w_squash_id_ex  = 1'b0;
    w_squash_ex_mem = 1'b0;
    w_pc_sel        = 1'b0;
    w_redirect_pc   = r_redirect_pc;
    case (r_state)
      StBoot: begin
        {w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb} = 4'hF;
        {w_squash_if_id, w_squash_id_ex, w_squash_ex_mem}          = 3'b111;
        w_state_d = StRun;
      end
      StRun: begin
        if (w_dstall) begin
          // Whole pipe frozen; a pending mispredict is re-presented once MEM completes.
        end else if (io_pipe.mispredict) begin
          {w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb} = 4'hF;
          {w_squash_if_id, w_squash_id_ex, w_squash_ex_mem}          = 3'b111;
          if (w_istall) begin
            w_capture = 1'b1;
            w_state_d = StDrain;
          end else begin
            w_pc_sel      = 1'b1;
            w_load_pc     = 1'b1;
            w_redirect_pc = io_pipe.redirect_target;
          end
        end else if (io_pipe.load_use) begin
          w_load_id_ex   = 1'b1;
          w_squash_id_ex = 1'b1;
          w_load_ex_mem  = 1'b1;
          w_load_mem_wb  = 1'b1;
        end else if (w_istall) begin
          {w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb} = 4'hF;
          w_squash_if_id = 1'b1;
        end else begin
          w_load_pc = 1'b1;
          {w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb} = 4'hF;
        end
      end
      StDrain: begin
        // Older stages are bubbles here, so mispredict is not looked at.
        if (!w_dstall) begin
          {w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb} = 4'hF;
          w_squash_if_id = 1'b1;
          if (io_pipe.imem_resp) begin
            w_pc_sel  = 1'b1;
            w_load_pc = 1'b1;
            w_state_d = StRun;
          end
        end
      end
      default: w_state_d = StBoot;
    endcase
  end

  // State register and the redirect target held across a drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StBoot;
      r_redirect_pc <= 16'h0000;
    end else begin
      r_state <= w_state_d;
      if (w_capture) r_redirect_pc <= io_pipe.redirect_target;
    end
  end

  // Enables and squashes are forced low while reset is held.
  assign io_pipe.load_pc         = reset_n & w_load_pc;
  assign io_pipe.load_if_id      = reset_n & w_load_if_id;
  assign io_pipe.load_id_ex      = reset_n & w_load_id_ex;
  assign io_pipe.load_ex_mem     = reset_n & w_load_ex_mem;
  assign io_pipe.load_mem_wb     = reset_n & w_load_mem_wb;
  assign io_pipe.squash_if_id    = reset_n & w_squash_if_id;
  assign io_pipe.squash_id_ex    = reset_n & w_squash_id_ex;
  assign io_pipe.squash_ex_mem   = reset_n & w_squash_ex_mem;
  assign io_pipe.pc_sel_redirect = reset_n & w_pc_sel;
  assign io_pipe.redirect_pc     = w_redirect_pc;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_squash_count;
  logic        w_stall_event;
  logic        w_squash_event;

  assign w_stall_event  = (r_state != StBoot) & ~(w_load_pc & w_load_if_id & w_load_id_ex);
  assign w_squash_event = (r_state == StRun) & ~w_dstall & io_pipe.mispredict;

  // Saturating perf counters; clear wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= 16'h0000;
      r_squash_count <= 16'h0000;
    end else if (io_pipe.perf_clr) begin
      r_stall_cycles <= 16'h0000;
      r_squash_count <= 16'h0000;
    end else begin
      if (w_stall_event && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_squash_event && r_squash_count != 16'hFFFF) r_squash_count <= r_squash_count + 16'd1;
    end
  end

  assign io_pipe.stall_cycles = r_stall_cycles;
  assign io_pipe.squash_count = r_squash_count;
`else
  logic w_unused_perf_clr;
  assign w_unused_perf_clr    = io_pipe.perf_clr;
  assign io_pipe.stall_cycles = 16'h0000;
  assign io_pipe.squash_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Control outputs are packed as
// {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
//  squash_if_id, squash_id_ex, squash_ex_mem, pc_sel_redirect}.
module tb_pipeline_ctrl;
  logic clk;
  logic reset_n;
  int   n_total;
  int   n_bad;

  pipeline_ctrl_if pif ();

  pipeline_ctrl u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_pipe (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] ctl;
  assign ctl = {pif.load_pc, pif.load_if_id, pif.load_id_ex, pif.load_ex_mem, pif.load_mem_wb,
                pif.squash_if_id, pif.squash_id_ex, pif.squash_ex_mem, pif.pc_sel_redirect};

  localparam logic [8:0] CtlZero  = 9'h000;
  localparam logic [8:0] CtlBoot  = 9'h0FE;
  localparam logic [8:0] CtlRun   = 9'h1F0;
  localparam logic [8:0] CtlMpNow = 9'h1FF;
  localparam logic [8:0] CtlMpDrn = 9'h0FE;
  localparam logic [8:0] CtlLdUse = 9'h074;
  localparam logic [8:0] CtlIstl  = 9'h0F8;
  localparam logic [8:0] CtlDrain = 9'h0F8;
  localparam logic [8:0] CtlDrOut = 9'h1F9;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are set #1 after a rising edge; outputs are checked mid-cycle, then advance one cycle.
  task automatic step(input string tag, input logic [8:0] exp_ctl,
                      input bit chk_rpc, input logic [15:0] exp_rpc);
    #4;
    chk(tag, {23'd0, ctl}, {23'd0, exp_ctl});
    if (chk_rpc) chk({tag, "_rpc"}, {16'd0, pif.redirect_pc}, {16'd0, exp_rpc});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pif.imem_req = 0; pif.imem_resp = 0; pif.dmem_req = 0; pif.dmem_resp = 0;
    pif.load_use = 0; pif.mispredict = 0; pif.redirect_target = 16'h0000; pif.perf_clr = 0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    idle_inputs();

    // Reset and boot
    repeat (2) @(posedge clk);
    #5;
    chk("rst_ctl", {23'd0, ctl}, 32'd0);
    chk("rst_rpc", {16'd0, pif.redirect_pc}, 32'd0);
    chk("rst_stall", {16'd0, pif.stall_cycles}, 32'd0);
    chk("rst_squash", {16'd0, pif.squash_count}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step("boot", CtlBoot, 0, 16'h0);
    step("run0", CtlRun, 0, 16'h0);
    step("run1", CtlRun, 0, 16'h0);

    // dstall hides a mispredict until dmem_resp
    pif.dmem_req = 1;
    step("dstall1", CtlZero, 0, 16'h0);
    pif.mispredict = 1; pif.redirect_target = 16'h4000;
    step("dstall2", CtlZero, 0, 16'h0);
    step("dstall3", CtlZero, 0, 16'h0);
    pif.dmem_resp = 1;
    step("dstall_mp", CtlMpNow, 1, 16'h4000);
    idle_inputs();
    step("after_dstall", CtlRun, 0, 16'h0);

    // load-use bubble for one cycle
    pif.load_use = 1;
    step("load_use", CtlLdUse, 0, 16'h0);
    pif.load_use = 0;
    step("after_lu", CtlRun, 0, 16'h0);

    // plain istall
    pif.imem_req = 1;
    step("istall", CtlIstl, 0, 16'h0);
    // dstall and istall together freeze everything
    pif.dmem_req = 1;
    step("d_and_i", CtlZero, 0, 16'h0);
    pif.dmem_req = 0;

    // mispredict with fetch in flight -> DRAIN; later mispredict in DRAIN ignored
    pif.mispredict = 1; pif.redirect_target = 16'h3A00;
    step("mp_drain", CtlMpDrn, 0, 16'h0);
    pif.mispredict = 1; pif.redirect_target = 16'h5555;
    step("drain_w1", CtlDrain, 0, 16'h0);
    pif.mispredict = 0;
    pif.dmem_req = 1;
    step("drain_dstl", CtlZero, 0, 16'h0);
    pif.dmem_req = 0;
    pif.imem_resp = 1;
    step("drain_out", CtlDrOut, 1, 16'h3A00);
    idle_inputs();
    step("drain_run", CtlRun, 0, 16'h0);

    // mispredict coincides with imem_resp: immediate redirect, no DRAIN
    pif.imem_req = 1; pif.imem_resp = 1; pif.mispredict = 1; pif.redirect_target = 16'h1234;
    step("mp_resp", CtlMpNow, 1, 16'h1234);
    idle_inputs();
    pif.imem_req = 1; pif.imem_resp = 1;
    step("mp_resp_run", CtlRun, 0, 16'h0);

    // reset mid-DRAIN abandons the pending redirect
    pif.imem_resp = 0; pif.mispredict = 1; pif.redirect_target = 16'hBEEF;
    step("mp_drain2", CtlMpDrn, 0, 16'h0);
    idle_inputs();
    reset_n = 1'b0;
    #4;
    chk("rst2_ctl", {23'd0, ctl}, 32'd0);
    chk("rst2_rpc", {16'd0, pif.redirect_pc}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step("boot2", CtlBoot, 0, 16'h0);
    pif.imem_req = 1; pif.imem_resp = 1;
    step("no_redirect", CtlRun, 0, 16'h0);
    idle_inputs();

`ifdef PIPE_CTRL_PERF_EN
    pif.perf_clr = 1;
    step("clr0", CtlRun, 0, 16'h0);
    pif.perf_clr = 0;
    chk("clr0_stall", {16'd0, pif.stall_cycles}, 32'd0);
    chk("clr0_squash", {16'd0, pif.squash_count}, 32'd0);
    pif.mispredict = 1; pif.redirect_target = 16'h0100;
    repeat (3) step("perf_mp", CtlMpNow, 0, 16'h0);
    pif.mispredict = 0;
    pif.load_use = 1;
    step("perf_lu", CtlLdUse, 0, 16'h0);
    pif.load_use = 0;
    chk("sq_count", {16'd0, pif.squash_count}, 32'd3);
    chk("stall_1", {16'd0, pif.stall_cycles}, 32'd1);
    pif.imem_req = 1;
    repeat (70000) @(posedge clk);
    #4;
    chk("stall_sat", {16'd0, pif.stall_cycles}, 32'hFFFF);
    pif.perf_clr = 1;
    @(posedge clk);
    #1 pif.perf_clr = 0;
    #4;
    chk("stall_clr", {16'd0, pif.stall_cycles}, 32'd0);
    chk("squash_clr", {16'd0, pif.squash_count}, 32'd0);
    idle_inputs();
`else
    pif.imem_req = 1; pif.perf_clr = 1;
    repeat (4) step("istall_np", CtlIstl, 0, 16'h0);
    idle_inputs();
    chk("np_stall", {16'd0, pif.stall_cycles}, 32'd0);
    chk("np_squash", {16'd0, pif.squash_count}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
